reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 24: width of GPRs, the link register (LR) and all data ports.
REQ-002 SHALL have parameter NREGS, default 16: GPR count; address width is 4 bits.
REQ-003 SHALL have parameter FLAG_W, default 4: flags register width.
REQ-004 SHALL have ports:
  clk  in  1  sole clock; all state updates on rising edge
  rst  in  1  synchronous, active-high reset
  reg_waddr  in  4  GPR write address from the write-back stage
  reg_wdata  in  DATA_W  GPR write data
  reg_we  in  1  GPR write enable
  lr_wdata  in  DATA_W  LR write data
  lr_we  in  1  LR write enable
  flag_wdata  in  FLAG_W  flags write data
  flag_we  in  1  flags write enable
  raddr_a  in  4  read port A address
  raddr_b  in  4  read port B address
  rdata_a  out  DATA_W  read port A data
  rdata_b  out  DATA_W  read port B data
  lr_rdata  out  DATA_W  current LR value
  flag_rdata  out  FLAG_W  current flags value
REQ-005 SHALL use one clock (clk) and a synchronous, active-high reset (rst); no other clock or asynchronous input.

Function
REQ-006 SHALL store NREGS GPRs, one LR and one flags register as independent storage.
REQ-007 SHALL write reg_wdata to GPR[reg_waddr] at the clk edge where reg_we=1 and rst=0; other GPRs unchanged.
REQ-008 SHALL write lr_wdata to LR at the edge where lr_we=1 and rst=0, independent of reg_we; both may write in the same cycle.
REQ-009 SHALL write flag_wdata to flags at the edge where flag_we=1 and rst=0, independent of the other enables.
REQ-010 SHALL treat GPR 0 as an ordinary writable register (no hardwired zero).
REQ-011 SHALL provide combinational reads: rdata_a = GPR[raddr_a], rdata_b = GPR[raddr_b], zero-cycle latency from address change.
REQ-012 SHALL allow raddr_a == raddr_b; both ports return the same value.
REQ-013 SHALL update stored values only on the clock edge; without bypass, a written value is visible on reads in the cycle after the write edge.
REQ-014 SHALL ignore writes while disabled; with all enables 0, every stored value holds indefinitely.

Reset
REQ-015 SHALL clear all GPRs, LR and flags to 0 at a clk edge with rst=1.
REQ-016 SHALL give rst priority over every write enable in the same cycle; the write is discarded.
REQ-017 SHALL drive rdata_a, rdata_b, lr_rdata and flag_rdata to 0 in the cycle after a reset edge, until the next write.
REQ-018 SHALL make reset mid-stream (rst pulsed between back-to-back writes) lose only the write coincident with rst; writes after rst deasserts apply normally.

Configuration
REQ-019 SHALL compile write-through bypass in only when macro REG_FILE_BYPASS_EN is defined.
REQ-020 With REG_FILE_BYPASS_EN: if reg_we=1, rst=0 and raddr_x==reg_waddr, rdata_x SHALL equal reg_wdata in the same cycle; lr_rdata SHALL equal lr_wdata when lr_we=1; flag_rdata SHALL equal flag_wdata when flag_we=1; no bypass while rst=1.
REQ-021 Without REG_FILE_BYPASS_EN: all read outputs SHALL reflect stored state only, per REQ-013.

Verification
REQ-022 rst 1 cycle, then read all 16 addresses -> every rdata = 0x000000, lr_rdata = 0, flag_rdata = 0.
REQ-023 reg_we=1, reg_waddr=5, reg_wdata=0xABCDEF, raddr_a=5 -> same cycle: 0xABCDEF with bypass, old value without; next cycle 0xABCDEF in both builds.
REQ-024 Same cycle reg_we=1 (R3=0x111111), lr_we=1 (0x222222), flag_we=1 (0xA) -> next cycle R3=0x111111, lr_rdata=0x222222, flag_rdata=0xA, other GPRs unchanged.
REQ-025 rst=1 with reg_we=1, reg_waddr=7, reg_wdata=0x123456 -> next cycle R7=0, no bypass of 0x123456 during rst.
REQ-026 Write R15=0xFFFFFF, then raddr_a=raddr_b=15 -> both ports 0xFFFFFF; R0 written 0x000001 reads back 0x000001.

Source files
------------

// File: rtl/reg_file.sv
// Register file: NREGS GPRs with two combinational read ports, plus a link register and a flags register.
// Optional same-cycle write-through bypass when REG_FILE_BYPASS_EN is defined.
module reg_file #(
    parameter int DATA_W = 24,
    parameter int NREGS  = 16,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        reg_waddr,
    input  logic [DATA_W-1:0] reg_wdata,
    input  logic              reg_we,
    input  logic [DATA_W-1:0] lr_wdata,
    input  logic              lr_we,
    input  logic [FLAG_W-1:0] flag_wdata,
    input  logic              flag_we,
    input  logic [3:0]        raddr_a,
    input  logic [3:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] lr_rdata,
    output logic [FLAG_W-1:0] flag_rdata
);

    localparam int ADDR_W = 4;

    logic [DATA_W-1:0] gpr [NREGS];
    logic [DATA_W-1:0] lr;
    logic [FLAG_W-1:0] flags;
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                gpr[i] <= '0;
            end
            lr    <= '0;
            flags <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_we && reg_waddr == ADDR_W'(i)) begin
                    gpr[i] <= reg_wdata;
                end
            end
            if (lr_we) begin
                lr <= lr_wdata;
            end
            if (flag_we) begin
                flags <= flag_wdata;
            end
        end
    end

    // Addresses beyond NREGS read as zero when the file is built smaller than 16.
    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (raddr_a == ADDR_W'(i)) begin
                stored_a = gpr[i];
            end
            if (raddr_b == ADDR_W'(i)) begin
                stored_b = gpr[i];
            end
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic byp_a;
    logic byp_b;

    assign byp_a = reg_we && !rst && (raddr_a == reg_waddr);
    assign byp_b = reg_we && !rst && (raddr_b == reg_waddr);

    assign rdata_a    = byp_a ? reg_wdata : stored_a;
    assign rdata_b    = byp_b ? reg_wdata : stored_b;
    assign lr_rdata   = (lr_we && !rst) ? lr_wdata : lr;
    assign flag_rdata = (flag_we && !rst) ? flag_wdata : flags;
`else
    assign rdata_a    = stored_a;
    assign rdata_b    = stored_b;
    assign lr_rdata   = lr;
    assign flag_rdata = flags;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected reads, a negedge monitor pops and compares.
// Expectations follow REG_FILE_BYPASS_EN the same way the design build does.
module tb_reg_file;

    localparam int DW = 24;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    reg_waddr = '0;
    logic [DW-1:0] reg_wdata = '0;
    logic          reg_we = 1'b0;
    logic [DW-1:0] lr_wdata = '0;
    logic          lr_we = 1'b0;
    logic [FW-1:0] flag_wdata = '0;
    logic          flag_we = 1'b0;
    logic [3:0]    raddr_a = '0;
    logic [3:0]    raddr_b = '0;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;
    logic [DW-1:0] lr_rdata;
    logic [FW-1:0] flag_rdata;

    reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .lr_wdata   (lr_wdata),
        .lr_we      (lr_we),
        .flag_wdata (flag_wdata),
        .flag_we    (flag_we),
        .raddr_a    (raddr_a),
        .raddr_b    (raddr_b),
        .rdata_a    (rdata_a),
        .rdata_b    (rdata_b),
        .lr_rdata   (lr_rdata),
        .flag_rdata (flag_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] lr;
        logic [FW-1:0] fl;
        string         tag;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: plain arrays holding the architectural state.
    logic [DW-1:0] m_gpr [16];
    logic [DW-1:0] m_lr;
    logic [FW-1:0] m_fl;
    bit            m_known = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".rdata_a"}, 32'(rdata_a), 32'(e.a));
            chk({e.tag, ".rdata_b"}, 32'(rdata_b), 32'(e.b));
            chk({e.tag, ".lr_rdata"}, 32'(lr_rdata), 32'(e.lr));
            chk({e.tag, ".flag_rdata"}, 32'(flag_rdata), 32'(e.fl));
        end
    end

    task automatic step(
        input string         tag,
        input bit            r,
        input bit            we,
        input logic [3:0]    wa,
        input logic [DW-1:0] wd,
        input bit            lwe,
        input logic [DW-1:0] lwd,
        input bit            fwe,
        input logic [FW-1:0] fwd,
        input logic [3:0]    ra,
        input logic [3:0]    rb
    );
        exp_t e;
        rst = r;
        reg_we = we;
        reg_waddr = wa;
        reg_wdata = wd;
        lr_we = lwe;
        lr_wdata = lwd;
        flag_we = fwe;
        flag_wdata = fwd;
        raddr_a = ra;
        raddr_b = rb;
        if (m_known) begin
            e.tag = tag;
            e.a = m_gpr[ra];
            e.b = m_gpr[rb];
            e.lr = m_lr;
            e.fl = m_fl;
`ifdef REG_FILE_BYPASS_EN
            if (!r && we && ra == wa) e.a = wd;
            if (!r && we && rb == wa) e.b = wd;
            if (!r && lwe) e.lr = lwd;
            if (!r && fwe) e.fl = fwd;
`endif
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            foreach (m_gpr[i]) m_gpr[i] = '0;
            m_lr = '0;
            m_fl = '0;
            m_known = 1'b1;
        end else begin
            if (we) m_gpr[wa] = wd;
            if (lwe) m_lr = lwd;
            if (fwe) m_fl = fwd;
        end
        #1;
    endtask

    task automatic rd(input string tag, input logic [3:0] ra, input logic [3:0] rb);
        step(tag, 0, 0, 4'd0, '0, 0, '0, 0, '0, ra, rb);
    endtask

    initial begin
        step("rst", 1, 0, 4'd0, '0, 0, '0, 0, '0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) rd("after_rst", 4'(i), 4'(15 - i));

        step("w5_same", 0, 1, 4'd5, 24'hABCDEF, 0, '0, 0, '0, 4'd5, 4'd6);
        rd("w5_next", 4'd5, 4'd5);

        step("multi_w", 0, 1, 4'd3, 24'h111111, 1, 24'h222222, 1, 4'hA, 4'd3, 4'd5);
        for (int i = 0; i < 16; i++) rd("multi_r", 4'(i), 4'd3);

        step("pre7", 0, 1, 4'd7, 24'h0F0F0F, 0, '0, 0, '0, 4'd0, 4'd0);
        step("rst_w7", 1, 1, 4'd7, 24'h123456, 1, 24'h654321, 1, 4'h5, 4'd7, 4'd7);
        rd("r7_after", 4'd7, 4'd3);

        step("w15", 0, 1, 4'd15, 24'hFFFFFF, 0, '0, 0, '0, 4'd0, 4'd0);
        rd("r15_both", 4'd15, 4'd15);
        step("w0", 0, 1, 4'd0, 24'h000001, 0, '0, 0, '0, 4'd1, 4'd2);
        rd("r0", 4'd0, 4'd15);

        step("ms_w1", 0, 1, 4'd1, 24'hAAAAAA, 0, '0, 0, '0, 4'd1, 4'd2);
        step("ms_rst", 1, 1, 4'd2, 24'hBBBBBB, 0, '0, 0, '0, 4'd1, 4'd2);
        step("ms_w3", 0, 1, 4'd3, 24'hCCCCCC, 1, 24'h000042, 0, '0, 4'd3, 4'd2);
        for (int i = 0; i < 4; i++) rd("ms_r", 4'(i), 4'(i + 4));

        for (int n = 0; n < 600; n++) begin
            step("rand",
                 ($urandom_range(0, 40) == 0),
                 1'($urandom), 4'($urandom), DW'($urandom),
                 1'($urandom), DW'($urandom),
                 1'($urandom), FW'($urandom),
                 4'($urandom), 4'($urandom));
        end

        for (int i = 0; i < 16; i++) rd("final", 4'(i), 4'(i));
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
